// File: rtl/fp_pkg.sv
// Shared floating-point format helpers for the N-operand adder.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;

  localparam logic [FP_EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp_t;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Smallest r with 2**r >= value.
  function automatic int fp_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_lead_one.sv
// Combinational priority encoder: index of the most significant set bit.
module fp_lead_one
  import fp_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int IDX_W = fp_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    idx_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        idx_o  = IDX_W'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_adder_n_pipe.sv
// Four-stage pipelined adder summing NUM_IN floating-point operands with a
// single normalisation and truncating rounding step at the end.
module fp_adder_n_pipe
  import fp_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int GUARD  = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_IN*(1+EXP_W+MAN_W)-1:0]   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [EXP_W+MAN_W:0]                out_data,
  output logic                                out_ovf
);

  localparam int W       = fp_width(EXP_W, MAN_W);
  localparam int VW      = MAN_W + GUARD + 1;                     // aligned magnitude
  localparam int SW      = MAN_W + GUARD + 2 + fp_clog2(NUM_IN);  // signed sum
  localparam int MW      = SW - 1;                                // sum magnitude
  localparam int HP      = MAN_W + GUARD;                         // hidden-bit position
  localparam int LW      = fp_clog2(MW);
  localparam int EW      = EXP_W + 2;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  logic stall;
  logic advance;

  logic                 s1_valid_q;
  logic [NUM_IN-1:0]    s1_sign_d, s1_sign_q;
  logic [EXP_W-1:0]     s1_exp_d   [NUM_IN];
  logic [EXP_W-1:0]     s1_exp_q   [NUM_IN];
  logic [VW-1:0]        s1_val_d   [NUM_IN];
  logic [VW-1:0]        s1_val_q   [NUM_IN];
  logic [EXP_W-1:0]     s1_maxexp_d, s1_maxexp_q;

  logic                 s2_valid_q;
  logic [SW-1:0]        s2_term_d  [NUM_IN];
  logic [SW-1:0]        s2_term_q  [NUM_IN];
  logic [EXP_W-1:0]     s2_maxexp_q;

  logic                 s3_valid_q;
  logic [SW-1:0]        s3_sum_d, s3_sum_q;
  logic [EXP_W-1:0]     s3_maxexp_q;

  logic                 res_sign;
  logic [MW-1:0]        res_mag;
  logic [MW-1:0]        res_norm;
  logic [LW-1:0]        lead_idx;
  logic                 mag_zero;
  logic [EW-1:0]        res_exp;     // two's complement
  logic [MAN_W-1:0]     res_man;
  logic [W-1:0]         out_data_d;
  logic                 out_ovf_d;

  logic                 out_valid_q;
  logic [W-1:0]         out_data_q;
  logic                 out_ovf_q;

  // The whole pipeline freezes only when a finished result is not taken.
  assign stall     = out_valid_q & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Unpack operands (zero exponent flushes to zero) and find the max exponent
  // with a heap-ordered comparison tree: leaves at NUM_IN.., root at 1.
  always_comb begin : s1_unpack
    logic [EXP_W-1:0] tree [1:2*NUM_IN-1];
    for (int i = 0; i < NUM_IN; i++) begin
      s1_sign_d[i] = in_data[i*W + W - 1];
      s1_exp_d[i]  = in_data[i*W + MAN_W +: EXP_W];
      if (s1_exp_d[i] == '0) s1_val_d[i] = '0;
      else s1_val_d[i] = {1'b1, in_data[i*W +: MAN_W], {GUARD{1'b0}}};
      tree[NUM_IN + i] = s1_exp_d[i];
    end
    for (int n = NUM_IN - 1; n >= 1; n--) begin
      tree[n] = (tree[2*n] > tree[2*n+1]) ? tree[2*n] : tree[2*n+1];
    end
    s1_maxexp_d = tree[1];
  end

  // Stage 1 register: unpacked operands and max exponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= '0;
      s1_maxexp_q <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        s1_exp_q[i] <= '0;
        s1_val_q[i] <= '0;
      end
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= s1_sign_d;
      s1_maxexp_q <= s1_maxexp_d;
      for (int i = 0; i < NUM_IN; i++) begin
        s1_exp_q[i] <= s1_exp_d[i];
        s1_val_q[i] <= s1_val_d[i];
      end
    end
  end

  // Align every operand to the max exponent and apply its sign. Large
  // differences are forced to zero explicitly rather than trusting the shifter.
  always_comb begin : s2_align
    logic [EXP_W-1:0] diff;
    logic [VW-1:0]    shifted;
    for (int i = 0; i < NUM_IN; i++) begin
      diff = s1_maxexp_q - s1_exp_q[i];
      if (int'(diff) >= VW) shifted = '0;
      else shifted = s1_val_q[i] >> diff;
      s2_term_d[i] = s1_sign_q[i] ? -SW'(shifted) : SW'(shifted);
    end
  end

  // Stage 2 register: signed aligned terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_maxexp_q <= '0;
      for (int i = 0; i < NUM_IN; i++) s2_term_q[i] <= '0;
    end else if (advance) begin
      s2_valid_q  <= s1_valid_q;
      s2_maxexp_q <= s1_maxexp_q;
      for (int i = 0; i < NUM_IN; i++) s2_term_q[i] <= s2_term_d[i];
    end
  end

  // Sum of all terms; SW carries enough headroom that it cannot overflow.
  always_comb begin
    s3_sum_d = '0;
    for (int i = 0; i < NUM_IN; i++) s3_sum_d = s3_sum_d + s2_term_q[i];
  end

  // Stage 3 register: exact signed sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q  <= 1'b0;
      s3_sum_q    <= '0;
      s3_maxexp_q <= '0;
    end else if (advance) begin
      s3_valid_q  <= s2_valid_q;
      s3_sum_q    <= s3_sum_d;
      s3_maxexp_q <= s2_maxexp_q;
    end
  end

  // The true magnitude always fits below the sign bit, so negate in MW bits.
  assign res_sign = s3_sum_q[SW-1];
  assign res_mag  = res_sign ? -s3_sum_q[MW-1:0] : s3_sum_q[MW-1:0];

  fp_lead_one #(
    .WIDTH (MW),
    .IDX_W (LW)
  ) u_lead_one (
    .data_i (res_mag),
    .idx_o  (lead_idx),
    .zero_o (mag_zero)
  );

  // Normalise the hidden bit to HP, drop guard bits, and classify the exponent.
  always_comb begin
    if (int'(lead_idx) >= HP) res_norm = res_mag >> (int'(lead_idx) - HP);
    else res_norm = res_mag << (HP - int'(lead_idx));
    res_man   = MAN_W'(res_norm >> GUARD);
    res_exp   = EW'(s3_maxexp_q) + EW'(lead_idx) - EW'(HP);
    out_ovf_d = 1'b0;
    if (mag_zero) begin
      out_data_d = '0;
    end else if (!res_exp[EW-1] && (res_exp >= EW'(EXP_MAX))) begin
      out_data_d = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_ovf_d  = 1'b1;
    end else if (res_exp[EW-1] || (res_exp == '0)) begin
      out_data_d = {res_sign, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      out_data_d = {res_sign, res_exp[EXP_W-1:0], res_man};
    end
  end

  // Output register; result fields only reload when a valid result arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        out_data_q <= out_data_d;
        out_ovf_q  <= out_ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_adder_n_pipe.sv
// Directed self-checking bench for the 4-operand single-precision adder.
module tb_fp_adder_n_pipe;
  import fp_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_ovf;

  int checks;
  int errors;

  fp_adder_n_pipe #(
    .NUM_IN (4),
    .EXP_W  (8),
    .MAN_W  (23),
    .GUARD  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] stream_x(input int j);
    return 32'h3F800000 + (32'(j) << 16);
  endfunction

  // Present one vector with the pipeline empty, then measure latency and result.
  task automatic run_vec(input string tag, input logic [127:0] v,
                         input logic [31:0] exp_d, input logic exp_o);
    int k;
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'd4);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
  endtask

  initial begin
    fp_t         one_f;
    logic [31:0] one;
    logic [31:0] inf_pat;
    logic [31:0] held;
    logic        stall_prev;
    int          sent;
    int          rcvd;

    checks = 0;
    errors = 0;
    one_f   = '{sign: 1'b0, exp: 8'(FP_BIAS), man: '0};
    one     = one_f;
    inf_pat = {1'b0, EXP_ALL_ONES, 23'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_vec("four_ones", pack4(one, one, one, one), 32'h40800000, 1'b0);
    run_vec("cancel", pack4(32'h3F800000, 32'hBF800000, 0, 0), 32'h00000000, 1'b0);
    run_vec("three_minus_one", pack4(32'h40400000, 32'hBF800000, 0, 0), 32'h40000000, 1'b0);
    run_vec("truncate", pack4(32'h3F800000, 32'h33800000, 0, 0), 32'h3F800000, 1'b0);
    run_vec("passthrough", pack4(32'h4B800000, 0, 0, 0), 32'h4B800000, 1'b0);
    run_vec("overflow", pack4(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000),
            inf_pat, 1'b1);
    run_vec("denormal", pack4(32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000),
            32'h00000000, 1'b0);
    run_vec("neg_two", pack4(32'hBF800000, 32'hBF800000, 0, 0), 32'hC0000000, 1'b0);
    run_vec("inf_in", pack4(32'h7F800000, 0, 0, 0), inf_pat, 1'b1);
    run_vec("underflow", pack4(32'h80C00000, 32'h00800000, 0, 0), 32'h80000000, 1'b0);

    // Streaming burst with a three-cycle output stall in the middle.
    sent       = 0;
    rcvd       = 0;
    stall_prev = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data", out_data, held);
      end
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid  = (sent < 10);
      in_data   = pack4(stream_x(sent), stream_x(sent), 0, 0);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, stream_x(rcvd) + 32'h00800000);
        rcvd++;
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(rcvd), 32'd10);
    chk("bp_sent", 32'(sent), 32'd10);
    repeat (4) begin
      @(negedge clk);
      chk("bp_no_dup", 32'(out_valid), 32'd0);
    end

    // Reset with results in flight: nothing may emerge afterwards.
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pack4(one, one, one, one);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_stale", 32'(out_valid), 32'd0);
    end

    run_vec("after_rst", pack4(one, one, one, one), 32'h40800000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
